// File: rtl/flex_data_packer.sv
// flex_data_packer: packs per-chain chunks of 1, M or N elements into dense
// N-element output vectors with ready/valid handshakes and end-of-frame flush.
// Optional idle auto-flush is built when PACKER_TIMEOUT_FLUSH_EN is defined.
module flex_data_packer #(
    parameter int unsigned N                            = 8,
    parameter int unsigned M                            = 2,
    parameter int unsigned DATA_WIDTH                   = 32,
    parameter int unsigned MAX_CHAINS                   = 4,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0,
    parameter int unsigned TIMEOUT                      = 64,
    localparam int unsigned CH_W  = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tracing,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic                              eof_in,
    input  logic [CH_W-1:0]                   chainId_in,
    input  logic [7:0]                        configId,
    input  logic [7:0]                        configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
    output logic [CNT_W-1:0]                  count_out,
    output logic                              eof_out,
    output logic                              valid_out,
    input  logic                              ready_out
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned BUF_D = 2 * N;

    if (N < 2 || M <= 1 || M >= N) begin : g_bad_len
        $error("flex_data_packer: requires N >= 2 and 1 < M < N");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("flex_data_packer: TIMEOUT must be nonzero");
    end

    typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]         buf_q [BUF_D];
    logic [DATA_WIDTH-1:0]         buf_d [BUF_D];
    logic [DATA_WIDTH-1:0]         merged [BUF_D];
    logic [N-1:0][DATA_WIDTH-1:0]  part_vec;
    logic [7:0]                    fw_q [MAX_CHAINS];
    logic [7:0]                    code;
    int unsigned                   len, fill, total, rem;
    logic [N-1:0][DATA_WIDTH-1:0]  vec_d;
    logic [CNT_W-1:0]              count_d;
    logic                          eof_d, valid_d;
    logic                          out_free, accept;

    assign out_free = !valid_out || ready_out;
    assign ready_in = (state_q == ACCUM) && out_free;
    assign accept   = valid_in && ready_in && tracing;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_hit;

    assign timeout_hit = (32'(idle_q) >= TIMEOUT) && (cnt_q != '0) &&
                         (state_q == ACCUM) && out_free;

    // Idle counter: cleared by accepts or an empty buffer, saturates at TIMEOUT
    always_comb begin
        idle_d = idle_q;
        if (accept || cnt_q == '0 || timeout_hit) begin
            idle_d = '0;
        end else if (32'(idle_q) < TIMEOUT) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    // Chunk length lookup and the buffer view with the incoming chunk appended
    always_comb begin
        code = 8'h00;
        if (32'(chainId_in) < MAX_CHAINS) code = fw_q[chainId_in];
        case (code)
            8'd0:    len = 1;
            8'd1:    len = M;
            default: len = N;
        endcase
        fill  = 32'(cnt_q);
        total = fill + len;
        rem   = (total >= N) ? total - N : 0;
        for (int unsigned i = 0; i < BUF_D; i++) begin
            if (i >= fill && i < total) merged[i] = vector_in[IDX_W'(i - fill)];
            else                        merged[i] = buf_q[i];
        end
        for (int unsigned i = 0; i < N; i++) begin
            part_vec[i] = (i < fill) ? buf_q[i] : '0;
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        vec_d   = vector_out;
        count_d = count_out;
        eof_d   = eof_out;
        valid_d = !out_free;
        if (accept) begin
            if (total >= N) begin
                for (int unsigned i = 0; i < N; i++) begin
                    vec_d[i]     = merged[i];
                    buf_d[i]     = merged[i + N];
                    buf_d[i + N] = '0;
                end
                count_d = CNT_W'(N);
                eof_d   = eof_in && (rem == 0);
                valid_d = 1'b1;
                cnt_d   = CNT_W'(rem);
                if (eof_in && rem != 0) state_d = FLUSH;
            end else if (eof_in) begin
                for (int unsigned i = 0; i < N; i++) begin
                    vec_d[i] = (i < total) ? merged[i] : '0;
                end
                for (int unsigned i = 0; i < BUF_D; i++) buf_d[i] = '0;
                count_d = CNT_W'(total);
                eof_d   = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                buf_d = merged;
                cnt_d = CNT_W'(total);
            end
        end else if (state_q == FLUSH) begin
            if (out_free) begin
                vec_d   = part_vec;
                count_d = cnt_q;
                eof_d   = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
                for (int unsigned i = 0; i < BUF_D; i++) buf_d[i] = '0;
                state_d = ACCUM;
            end
        end
`ifdef PACKER_TIMEOUT_FLUSH_EN
        else if (timeout_hit) begin
            vec_d   = part_vec;
            count_d = cnt_q;
            eof_d   = 1'b0;
            valid_d = 1'b1;
            cnt_d   = '0;
            for (int unsigned i = 0; i < BUF_D; i++) buf_d[i] = '0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    // Fill count, element buffer and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            for (int unsigned i = 0; i < BUF_D; i++) buf_q[i] <= '0;
            vector_out <= '0;
            count_out  <= '0;
            eof_out    <= 1'b0;
            valid_out  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            for (int unsigned i = 0; i < BUF_D; i++) buf_q[i] <= buf_d[i];
            vector_out <= vec_d;
            count_out  <= count_d;
            eof_out    <= eof_d;
            valid_out  <= valid_d;
        end
    end

    // Firmware length codes; out-of-range slot selects are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_CHAINS; i++) fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
        end else if (32'(configId) < MAX_CHAINS) begin
            fw_q[configId[CH_W-1:0]] <= configData;
        end
    end

endmodule
